race_arbiter: RTL and testbench



---
 rtl/race_arbiter.sv | 127 ++++++++++++
 tb/tb_race_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/race_arbiter.sv
// race_arbiter -- decides which of two RO counters finished first and
// produces one PUF response bit per race.
//
// Optional feature: define RACE_ARBITER_SYNC_EN to pass finished1/finished2
// through 2-flop synchronizers before the FSM. This is for counters clocked
// by RO-derived clocks, and it adds 2 cycles of decision latency. Without the
// macro the finish flags are sampled directly and must be synchronous to clk.
module race_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic finished1,
  input  logic finished2,
  output logic out,
  output logic valid,
  output logic tie
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DECIDED = 2'd2
  } state_e;

  // Bit 0 carries counter 1 and bit 1 carries counter 2.
  logic [1:0] fin_raw;
  logic [1:0] fin_s;

  assign fin_raw = {finished2, finished1};

`ifdef RACE_ARBITER_SYNC_EN
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_q;
      logic sync_q;

      // Two-flop synchronizer per finish flag, cleared by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
        end else begin
          meta_q <= fin_raw[gi];
          sync_q <= meta_q;
        end
      end

      assign fin_s[gi] = sync_q;
    end
  endgenerate
`else
  assign fin_s = fin_raw;
`endif

  state_e state_q;
  logic   out_q;
  logic   valid_q;
  logic   tie_q;

  // Race FSM. All outputs are registered here, so no input reaches an output
  // combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      tie_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // out keeps the last response so the collector can read it late.
          valid_q <= 1'b0;
          tie_q   <= 1'b0;
          if (enable) begin
            state_q <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!enable) begin
            // Abort: no decision is made and out is left untouched.
            state_q <= ST_IDLE;
          end else begin
            case (fin_s)
              2'b01: begin
                out_q   <= 1'b1;
                valid_q <= 1'b1;
                state_q <= ST_DECIDED;
              end
              2'b10: begin
                out_q   <= 1'b0;
                valid_q <= 1'b1;
                state_q <= ST_DECIDED;
              end
              2'b11: begin
                tie_q   <= 1'b1;
                valid_q <= 1'b0;
                state_q <= ST_DECIDED;
              end
              default: begin
                state_q <= ST_ARMED;
              end
            endcase
          end
        end
        ST_DECIDED: begin
          // Hold the decision. Later finish activity is ignored until re-arm.
          if (!enable) begin
            valid_q <= 1'b0;
            tie_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          tie_q   <= 1'b0;
        end
      endcase
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign tie   = tie_q;

endmodule

// File: tb/tb_race_arbiter.sv
// tb_race_arbiter -- scoreboard bench for race_arbiter. The stimulus process
// queues each expected decision, which holds out, tie and the cycle in which
// it must appear. A monitor pops an entry whenever valid or tie rises and
// compares it. Build with or without RACE_ARBITER_SYNC_EN. The expected
// latency follows that macro.
module tb_race_arbiter;

`ifdef RACE_ARBITER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  logic enable;
  logic finished1;
  logic finished2;
  logic out;
  logic valid;
  logic tie;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic o;
    logic t;
    int   c;
  } exp_t;

  exp_t exp_q[$];

  race_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .finished1(finished1),
    .finished2(finished2),
    .out      (out),
    .valid    (valid),
    .tie      (tie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, req, cyc);
    end else begin
      $display("ok   %s: %b (cycle %0d)", nm, act, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after the finish inputs change at a negedge. The first
  // sampling edge is cyc+1, so the decision becomes visible at cyc+LAT.
  task automatic expect_decision(input logic o, input logic t);
    exp_t e;
    e.o = o;
    e.t = t;
    e.c = cyc + LAT;
    exp_q.push_back(e);
  endtask

  // Monitor: on a rising valid or tie, pop and compare.
  logic prev_v = 1'b0;
  logic prev_t = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && ((valid === 1'b1 && !prev_v) || (tie === 1'b1 && !prev_t))) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_decision: got out=%b valid=%b tie=%b expected none (cycle %0d)",
                 out, valid, tie, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("decision: out=%b valid=%b tie=%b at cycle %0d (expected out=%b tie=%b cycle %0d)",
                 out, valid, tie, cyc, e.o, e.t, e.c);
        check("mon_out", out, e.o);
        check("mon_tie", tie, e.t);
        check("mon_valid", valid, ~e.t);
        n_cmp++;
        if (cyc != e.c) begin
          n_bad++;
          $display("FAIL mon_latency: got cycle %0d expected cycle %0d", cyc, e.c);
        end
      end
    end
    prev_v = (valid === 1'b1);
    prev_t = (tie === 1'b1);
  end

  initial begin
    rst_n     = 1'b1;
    enable    = 1'b1;
    finished1 = 1'b1;
    finished2 = 1'b0;

    // Reset is asserted while finished1 and enable are high.
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_now", out, 1'b0);
    check("rst_valid_now", valid, 1'b0);
    check("rst_tie_now", tie, 1'b0);
    tick(3);
    check("rst_out_held", out, 1'b0);
    check("rst_valid_held", valid, 1'b0);
    check("rst_tie_held", tie, 1'b0);
    enable    = 1'b0;
    finished1 = 1'b0;
    rst_n     = 1'b1;
    tick(2);

    // Counter 2 wins. Raise finished2, then a late finished1.
    enable = 1'b1;
    tick(1);
    tick(3);
    finished2 = 1'b1;
    expect_decision(1'b0, 1'b0);
    tick(2);
    finished1 = 1'b1;
    tick(4);
    check("c2_out_hold", out, 1'b0);
    check("c2_valid_hold", valid, 1'b1);

    // Counter 1 wins after a single idle cycle.
    enable    = 1'b0;
    finished1 = 1'b0;
    finished2 = 1'b0;
    tick(1);
    check("idle_valid_low", valid, 1'b0);
    enable = 1'b1;
    tick(1);
    finished1 = 1'b1;
    expect_decision(1'b1, 1'b0);
    tick(LAT + 2);
    check("c1_out", out, 1'b1);

    // Tie with out=1. Raise both finishes on the same edge.
    enable    = 1'b0;
    finished1 = 1'b0;
    tick(1);
    enable = 1'b1;
    tick(2);
    finished1 = 1'b1;
    finished2 = 1'b1;
    expect_decision(1'b1, 1'b1);
    tick(LAT + 2);
    check("tie_flag", tie, 1'b1);
    check("tie_valid_low", valid, 1'b0);
    check("tie_out_kept", out, 1'b1);
    enable    = 1'b0;
    finished1 = 1'b0;
    finished2 = 1'b0;
    tick(1);
    check("tie_cleared", tie, 1'b0);
    check("tie_out_after", out, 1'b1);

    // Abort. Arm, then drop enable before any finish.
    enable = 1'b1;
    tick(3);
    enable = 1'b0;
    tick(2);
    check("abort_valid", valid, 1'b0);
    check("abort_tie", tie, 1'b0);
    check("abort_out_kept", out, 1'b1);

    // Reset in mid-race. A finish rises but reset lands before it is sampled.
    enable = 1'b1;
    tick(2);
    finished2 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", out, 1'b0);
    check("midrst_valid", valid, 1'b0);
    enable    = 1'b0;
    finished2 = 1'b0;
    tick(2);
    check("midrst_tie", tie, 1'b0);
    rst_n = 1'b1;
    tick(1);
    enable = 1'b1;
    tick(1);
    finished1 = 1'b1;
    expect_decision(1'b1, 1'b0);
    tick(LAT + 3);
    check("post_rst_out", out, 1'b1);
    check("post_rst_valid", valid, 1'b1);

    enable    = 1'b0;
    finished1 = 1'b0;
    tick(3);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_decision: got no decision expected out=%b tie=%b at cycle %0d",
               e.o, e.t, e.c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
